mmix_mem_responder: RTL



---
 rtl/mmix_mem_responder_if.sv | 36 +++
 rtl/mmix_mem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmix_mem_responder_if.sv
// Execution-unit data-memory request port bundled with the Avalon-MM master port.
// "slave" is the responder's view; "master" is the requester plus board memory.
interface mmix_mem_responder_if #(
    parameter int ADDR_BITS = 23
);
    logic [63:0]          mem_address;
    logic [1:0]           mem_datasize;
    logic                 mem_read;
    logic                 mem_write;
    logic [63:0]          mem_writedata;
    logic [63:0]          mem_readdata;
    logic                 mem_done;

    logic [ADDR_BITS-1:0] avm_address;
    logic                 avm_read;
    logic                 avm_write;
    logic [3:0]           avm_byteenable;
    logic [31:0]          avm_writedata;
    logic [31:0]          avm_readdata;
    logic                 avm_readdatavalid;
    logic                 avm_waitrequest;

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done,
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done,
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/mmix_mem_responder.sv
// Turns one big-endian MMIX byte/wyde/tetra/octa load or store into one or two
// 32-bit Avalon-MM beats and returns right-justified, zero-extended load data.
module mmix_mem_responder #(
    parameter int ADDR_BITS = 23
) (
    input  logic                clk,
    input  logic                reset_n,
    mmix_mem_responder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               r_state, w_state;
    logic                 r_beat, w_beat;
    logic [ADDR_BITS-1:0] r_addr, w_addr;
    logic [1:0]           r_size, w_size;
    logic [63:0]          r_wdata, w_wdata;
    logic [63:0]          r_mem_readdata, w_mem_readdata;
    logic                 r_mem_done, w_mem_done;
    logic [ADDR_BITS-1:0] r_avm_address, w_avm_address;
    logic                 r_avm_read, w_avm_read;
    logic                 r_avm_write, w_avm_write;
    logic [3:0]           r_avm_be, w_avm_be;
    logic [31:0]          r_avm_wdata, w_avm_wdata;
    logic                 w_unused_addr;

    // Word address of a beat; an octa's second beat sits at base+4.
    function automatic logic [ADDR_BITS-1:0] beat_addr_f(input logic [ADDR_BITS-1:0] a,
                                                         input logic [1:0] size,
                                                         input logic beat);
        logic [ADDR_BITS-1:0] v;
        v      = a;
        v[1:0] = 2'b00;
        if (size == 2'd3) begin
            v[2] = beat;
        end else begin
            v[2] = a[2];
        end
        return v;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b1000 >> lo;
            2'd1:    be = 4'b1100 >> {lo[1], 1'b0};
            default: be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [63:0] d,
                                            input logic beat);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            2'd2:    w = d[31:0];
            default: w = beat ? d[31:0] : d[63:32];
        endcase
        return w;
    endfunction

    // Big-endian lane pick: MMIX byte j of the word lives at bits [31-8j:24-8j].
    function automatic logic [63:0] rd_merge_f(input logic [1:0] size, input logic [1:0] lo,
                                               input logic beat, input logic [31:0] rd,
                                               input logic [63:0] old);
        logic [63:0] v;
        logic [31:0] tmp;
        logic [4:0]  sh;
        case (size)
            2'd0: begin
                sh  = 5'd24 - {lo, 3'b000};
                tmp = rd >> sh;
                v   = {56'd0, tmp[7:0]};
            end
            2'd1: begin
                sh  = 5'd16 - {lo[1], 4'b0000};
                tmp = rd >> sh;
                v   = {48'd0, tmp[15:0]};
            end
            2'd2: begin
                sh  = 5'd0;
                tmp = rd;
                v   = {32'd0, rd};
            end
            default: begin
                sh  = 5'd0;
                tmp = rd;
                v   = beat ? {old[63:32], rd} : {rd, old[31:0]};
            end
        endcase
        return v;
    endfunction

    assign w_unused_addr = ^bus.mem_address[63:ADDR_BITS];

    // Next-state and next-output logic; every output is the registered image of these.
    always_comb begin
        w_state        = r_state;
        w_beat         = r_beat;
        w_addr         = r_addr;
        w_size         = r_size;
        w_wdata        = r_wdata;
        w_mem_readdata = r_mem_readdata;
        w_mem_done     = 1'b0;
        w_avm_address  = r_avm_address;
        w_avm_read     = r_avm_read;
        w_avm_write    = r_avm_write;
        w_avm_be       = r_avm_be;
        w_avm_wdata    = r_avm_wdata;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_read) begin
                    w_addr         = bus.mem_address[ADDR_BITS-1:0];
                    w_size         = bus.mem_datasize;
                    w_wdata        = bus.mem_writedata;
                    w_beat         = 1'b0;
                    w_mem_readdata = 64'd0;
                    w_avm_address  = beat_addr_f(bus.mem_address[ADDR_BITS-1:0], bus.mem_datasize, 1'b0);
                    w_avm_read     = 1'b1;
                    w_avm_be       = 4'hF;
                    w_state        = S_RD_REQ;
                end else if (bus.mem_write) begin
                    w_addr        = bus.mem_address[ADDR_BITS-1:0];
                    w_size        = bus.mem_datasize;
                    w_wdata       = bus.mem_writedata;
                    w_beat        = 1'b0;
                    w_avm_address = beat_addr_f(bus.mem_address[ADDR_BITS-1:0], bus.mem_datasize, 1'b0);
                    w_avm_write   = 1'b1;
                    w_avm_be      = be_f(bus.mem_datasize, bus.mem_address[1:0]);
                    w_avm_wdata   = wdata_f(bus.mem_datasize, bus.mem_writedata, 1'b0);
                    w_state       = S_WR_REQ;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (!bus.avm_waitrequest) begin
                    w_avm_read = 1'b0;
                    w_state    = S_RD_WAIT;
                end else begin
                    w_state = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                if (bus.avm_readdatavalid) begin
                    w_mem_readdata = rd_merge_f(r_size, r_addr[1:0], r_beat, bus.avm_readdata, r_mem_readdata);
                    if ((r_size == 2'd3) && !r_beat) begin
                        w_beat        = 1'b1;
                        w_avm_address = beat_addr_f(r_addr, r_size, 1'b1);
                        w_avm_read    = 1'b1;
                        w_state       = S_RD_REQ;
                    end else begin
                        w_mem_done = 1'b1;
                        w_state    = S_DONE;
                    end
                end else begin
                    w_state = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                if (!bus.avm_waitrequest) begin
                    if ((r_size == 2'd3) && !r_beat) begin
                        w_beat        = 1'b1;
                        w_avm_address = beat_addr_f(r_addr, r_size, 1'b1);
                        w_avm_wdata   = wdata_f(r_size, r_wdata, 1'b1);
                        w_state       = S_WR_REQ;
                    end else begin
                        w_avm_write = 1'b0;
                        w_mem_done  = 1'b1;
                        w_state     = S_DONE;
                    end
                end else begin
                    w_state = S_WR_REQ;
                end
            end
            S_DONE: begin
                w_beat  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_beat         <= 1'b0;
            r_addr         <= '0;
            r_size         <= 2'd0;
            r_wdata        <= 64'd0;
            r_mem_readdata <= 64'd0;
            r_mem_done     <= 1'b0;
            r_avm_address  <= '0;
            r_avm_read     <= 1'b0;
            r_avm_write    <= 1'b0;
            r_avm_be       <= 4'd0;
            r_avm_wdata    <= 32'd0;
        end else begin
            r_state        <= w_state;
            r_beat         <= w_beat;
            r_addr         <= w_addr;
            r_size         <= w_size;
            r_wdata        <= w_wdata;
            r_mem_readdata <= w_mem_readdata;
            r_mem_done     <= w_mem_done;
            r_avm_address  <= w_avm_address;
            r_avm_read     <= w_avm_read;
            r_avm_write    <= w_avm_write;
            r_avm_be       <= w_avm_be;
            r_avm_wdata    <= w_avm_wdata;
        end
    end

    assign bus.mem_readdata   = r_mem_readdata;
    assign bus.mem_done       = r_mem_done;
    assign bus.avm_address    = r_avm_address;
    assign bus.avm_read       = r_avm_read;
    assign bus.avm_write      = r_avm_write;
    assign bus.avm_byteenable = r_avm_be;
    assign bus.avm_writedata  = r_avm_wdata;

endmodule
